// File: rtl/fir_stage_scheduler_if.sv
// Request/status bundle between the decimation stages and the shared-MAC scheduler.
// master drives sample-valid pulses and overrun clear; slave returns the MAC sequencing strobes.
interface fir_stage_scheduler_if #(
  parameter int TW = 4
);
  logic [3:0]    req_in;
  logic          ovr_clr_in;
  logic          busy_out;
  logic [1:0]    stage_out;
  logic [TW-1:0] tap_out;
  logic          mac_en_out;
  logic          mac_clear_out;
  logic          done_out;
  logic [3:0]    overrun_out;

  modport master (
    output req_in,
    output ovr_clr_in,
    input  busy_out,
    input  stage_out,
    input  tap_out,
    input  mac_en_out,
    input  mac_clear_out,
    input  done_out,
    input  overrun_out
  );

  modport slave (
    input  req_in,
    input  ovr_clr_in,
    output busy_out,
    output stage_out,
    output tap_out,
    output mac_en_out,
    output mac_clear_out,
    output done_out,
    output overrun_out
  );
endinterface

// File: rtl/fir_stage_scheduler.sv
// Time-shares one MAC across four decimation stages: fixed priority, one NUM_TAPS pass per sample.
// Grant one cycle after the pending bit registers; no backpressure, a second sample while queued flags overrun.
module fir_stage_scheduler #(
  parameter int NUM_TAPS = 16,
  parameter int TW       = $clog2(NUM_TAPS)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  fir_stage_scheduler_if.slave  sched_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);

  state_e        state_q,     state_d;
  logic [3:0]    pending_q,   pending_d;
  logic [3:0]    overrun_q,   overrun_d;
  logic [1:0]    stage_q,     stage_d;
  logic [TW-1:0] tap_q,       tap_d;
  logic          mac_en_q,    mac_en_d;
  logic          mac_clear_q, mac_clear_d;
  logic          done_q,      done_d;
  logic          busy_q,      busy_d;

  logic [3:0]    grant_vec;
  logic [1:0]    grant_idx;
  logic [3:0]    ovr_evt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      overrun_q   <= '0;
      stage_q     <= '0;
      tap_q       <= '0;
      mac_en_q    <= 1'b0;
      mac_clear_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      stage_q     <= stage_d;
      tap_q       <= tap_d;
      mac_en_q    <= mac_en_d;
      mac_clear_q <= mac_clear_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    tap_d       = tap_q;
    mac_en_d    = 1'b0;
    mac_clear_d = 1'b0;
    done_d      = 1'b0;
    grant_vec   = '0;
    grant_idx   = '0;

    // Descending scan leaves the lowest set index, so stage 0 wins.
    for (int k = 3; k >= 0; k--) begin
      if (pending_q[k]) grant_idx = 2'(k);
    end

    case (state_q)
      S_IDLE: begin
        if (|pending_q) begin
          state_d     = S_RUN;
          stage_d     = grant_idx;
          tap_d       = '0;
          mac_en_d    = 1'b1;
          mac_clear_d = 1'b1;
          grant_vec   = 4'b0001 << grant_idx;
        end
      end
      S_RUN: begin
        if (tap_q == LAST_TAP) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          tap_d    = tap_q + TW'(1);
          mac_en_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);

    // A request coinciding with the grant re-queues that stage rather than overrunning it.
    ovr_evt   = sched_if.req_in & pending_q & ~grant_vec;
    pending_d = (pending_q & ~grant_vec) | sched_if.req_in;
    overrun_d = (sched_if.ovr_clr_in ? 4'b0000 : overrun_q) | ovr_evt;
  end

  assign sched_if.busy_out      = busy_q;
  assign sched_if.stage_out     = stage_q;
  assign sched_if.tap_out       = tap_q;
  assign sched_if.mac_en_out    = mac_en_q;
  assign sched_if.mac_clear_out = mac_clear_q;
  assign sched_if.done_out      = done_q;
  assign sched_if.overrun_out   = overrun_q;

endmodule

// File: tb/tb_fir_stage_scheduler.sv
// Directed and model-checked scenarios for fir_stage_scheduler with NUM_TAPS=16.
module tb_fir_stage_scheduler;
  localparam int N  = 16;
  localparam int TW = 4;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   tests_run    = 0;
  int   tests_failed = 0;

  fir_stage_scheduler_if #(.TW(TW)) sched_if ();

  fir_stage_scheduler #(.NUM_TAPS(N), .TW(TW)) dut (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .sched_if (sched_if)
  );

  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [9:0] obs();
    return {sched_if.busy_out, sched_if.stage_out, sched_if.tap_out,
            sched_if.mac_en_out, sched_if.mac_clear_out, sched_if.done_out};
  endfunction

  function automatic logic [9:0] pack(logic b, logic [1:0] s, logic [3:0] t,
                                      logic e, logic c, logic d);
    return {b, s, t, e, c, d};
  endfunction

  task automatic test_reset();
    rst_in = 1'b1;
    sched_if.req_in = 4'hF;
    sched_if.ovr_clr_in = 1'b0;
    step();
    step();
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got %h want 0", {obs(), sched_if.overrun_out});
    end
    sched_if.req_in = 4'h0;
    rst_in = 1'b0;
    step();
    step();
    step();
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== 14'h0) begin
      tests_failed++;
      $display("FAIL reset_req_ignored: got %h want 0", {obs(), sched_if.overrun_out});
    end
  endtask

  task automatic test_single();
    sched_if.req_in = 4'b0100;
    step();
    sched_if.req_in = 4'b0000;
    tests_run++;
    if (obs() !== pack(0, 0, 0, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL single_grant_cycle: got %h want %h", obs(), pack(0, 0, 0, 0, 0, 0));
    end
    step();
    for (int i = 0; i < N; i++) begin
      tests_run++;
      if (obs() !== pack(1, 2, 4'(i), 1, (i == 0), 0)) begin
        tests_failed++;
        $display("FAIL single_run tap%0d: got %h want %h", i, obs(), pack(1, 2, 4'(i), 1, (i == 0), 0));
      end
      step();
    end
    tests_run++;
    if (obs() !== pack(1, 2, 15, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL single_done: got %h want %h", obs(), pack(1, 2, 15, 0, 0, 1));
    end
    step();
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== {pack(0, 2, 15, 0, 0, 0), 4'b0000}) begin
      tests_failed++;
      $display("FAIL single_idle: got %h want %h", {obs(), sched_if.overrun_out}, {pack(0, 2, 15, 0, 0, 0), 4'b0000});
    end
  endtask

  task automatic test_multi();
    logic [1:0] order [3];
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd3;
    sched_if.req_in = 4'b1011;
    step();
    sched_if.req_in = 4'b0000;
    step();
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < N; i++) begin
        tests_run++;
        if (obs() !== pack(1, order[p], 4'(i), 1, (i == 0), 0)) begin
          tests_failed++;
          $display("FAIL multi_run pass%0d tap%0d: got %h want %h", p, i, obs(), pack(1, order[p], 4'(i), 1, (i == 0), 0));
        end
        step();
      end
      tests_run++;
      if (obs() !== pack(1, order[p], 15, 0, 0, 1)) begin
        tests_failed++;
        $display("FAIL multi_done pass%0d: got %h want %h", p, obs(), pack(1, order[p], 15, 0, 0, 1));
      end
      step();
      tests_run++;
      if (obs() !== pack(0, order[p], 15, 0, 0, 0)) begin
        tests_failed++;
        $display("FAIL multi_idle pass%0d: got %h want %h", p, obs(), pack(0, order[p], 15, 0, 0, 0));
      end
      step();
    end
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== {pack(0, 3, 15, 0, 0, 0), 4'b0000}) begin
      tests_failed++;
      $display("FAIL multi_final: got %h want %h", {obs(), sched_if.overrun_out}, {pack(0, 3, 15, 0, 0, 0), 4'b0000});
    end
  endtask

  task automatic test_overrun();
    int dones;
    logic [3:0] seq;
    logic bad_stage;
    // Re-request landing on the grant cycle: re-queued, no overrun.
    sched_if.req_in = 4'b0001;
    step();
    sched_if.req_in = 4'b0001;
    step();
    sched_if.req_in = 4'b0000;
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== {pack(1, 0, 0, 1, 1, 0), 4'b0000}) begin
      tests_failed++;
      $display("FAIL ovr_grant_cycle: got %h want %h", {obs(), sched_if.overrun_out}, {pack(1, 0, 0, 1, 1, 0), 4'b0000});
    end
    dones = 0;
    bad_stage = 1'b0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sched_if.done_out) begin
        dones++;
        if (sched_if.stage_out !== 2'd0) bad_stage = 1'b1;
      end
    end
    tests_run++;
    if ({dones[3:0], bad_stage, sched_if.busy_out, sched_if.overrun_out} !== {4'd2, 1'b0, 1'b0, 4'b0000}) begin
      tests_failed++;
      $display("FAIL ovr_requeue_passes: got dones=%0d bad=%b busy=%b ovr=%b want dones=2 bad=0 busy=0 ovr=0000",
               dones, bad_stage, sched_if.busy_out, sched_if.overrun_out);
    end

    // Stage 1 running, stage 0 queued then hit again.
    sched_if.req_in = 4'b0010;
    step();
    sched_if.req_in = 4'b0000;
    step();
    sched_if.req_in = 4'b0001;
    step();
    tests_run++;
    if (sched_if.overrun_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ovr_first_queue: got %b want 0000", sched_if.overrun_out);
    end
    sched_if.req_in = 4'b0001;
    step();
    sched_if.req_in = 4'b0000;
    tests_run++;
    if ({sched_if.overrun_out, sched_if.stage_out, sched_if.busy_out} !== {4'b0001, 2'd1, 1'b1}) begin
      tests_failed++;
      $display("FAIL ovr_set: got ovr=%b stage=%0d busy=%b want ovr=0001 stage=1 busy=1",
               sched_if.overrun_out, sched_if.stage_out, sched_if.busy_out);
    end
    sched_if.ovr_clr_in = 1'b1;
    sched_if.req_in = 4'b0001;
    step();
    sched_if.req_in = 4'b0000;
    tests_run++;
    if (sched_if.overrun_out !== 4'b0001) begin
      tests_failed++;
      $display("FAIL ovr_clr_vs_event: got %b want 0001", sched_if.overrun_out);
    end
    step();
    sched_if.ovr_clr_in = 1'b0;
    tests_run++;
    if (sched_if.overrun_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL ovr_clear: got %b want 0000", sched_if.overrun_out);
    end
    dones = 0;
    seq = 4'hF;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sched_if.done_out) begin
        if (dones < 2) seq = {seq[1:0], sched_if.stage_out};
        dones++;
      end
    end
    tests_run++;
    if ({dones[3:0], seq, sched_if.busy_out} !== {4'd2, 2'd1, 2'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL ovr_drain: got dones=%0d seq=%b busy=%b want dones=2 seq=0100 busy=0",
               dones, seq, sched_if.busy_out);
    end
  endtask

  task automatic test_back_to_back();
    sched_if.req_in = 4'b0010;
    step();
    sched_if.req_in = 4'b0000;
    step();
    step();
    step();
    step();
    tests_run++;
    if (obs() !== pack(1, 1, 3, 1, 0, 0)) begin
      tests_failed++;
      $display("FAIL b2b_mid: got %h want %h", obs(), pack(1, 1, 3, 1, 0, 0));
    end
    sched_if.req_in = 4'b0010;
    step();
    sched_if.req_in = 4'b0000;
    tests_run++;
    if (sched_if.overrun_out !== 4'b0000) begin
      tests_failed++;
      $display("FAIL b2b_no_overrun: got %b want 0000", sched_if.overrun_out);
    end
    repeat (12) step();
    tests_run++;
    if (obs() !== pack(1, 1, 15, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL b2b_done1: got %h want %h", obs(), pack(1, 1, 15, 0, 0, 1));
    end
    step();
    tests_run++;
    if (obs() !== pack(0, 1, 15, 0, 0, 0)) begin
      tests_failed++;
      $display("FAIL b2b_idle: got %h want %h", obs(), pack(0, 1, 15, 0, 0, 0));
    end
    step();
    tests_run++;
    if (obs() !== pack(1, 1, 0, 1, 1, 0)) begin
      tests_failed++;
      $display("FAIL b2b_second_start: got %h want %h", obs(), pack(1, 1, 0, 1, 1, 0));
    end
    repeat (16) step();
    tests_run++;
    if (obs() !== pack(1, 1, 15, 0, 0, 1)) begin
      tests_failed++;
      $display("FAIL b2b_done2: got %h want %h", obs(), pack(1, 1, 15, 0, 0, 1));
    end
    step();
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== {pack(0, 1, 15, 0, 0, 0), 4'b0000}) begin
      tests_failed++;
      $display("FAIL b2b_end: got %h want %h", {obs(), sched_if.overrun_out}, {pack(0, 1, 15, 0, 0, 0), 4'b0000});
    end
  endtask

  task automatic test_reset_mid();
    logic activity;
    sched_if.req_in = 4'b1001;
    step();
    sched_if.req_in = 4'b0000;
    step();
    step();
    step();
    sched_if.req_in = 4'b1000;
    step();
    sched_if.req_in = 4'b0000;
    tests_run++;
    if (sched_if.overrun_out !== 4'b1000) begin
      tests_failed++;
      $display("FAIL rstmid_overrun_pre: got %b want 1000", sched_if.overrun_out);
    end
    repeat (4) step();
    tests_run++;
    if (obs() !== pack(1, 0, 7, 1, 0, 0)) begin
      tests_failed++;
      $display("FAIL rstmid_tap7: got %h want %h", obs(), pack(1, 0, 7, 1, 0, 0));
    end
    rst_in = 1'b1;
    sched_if.req_in = 4'b0100;
    step();
    sched_if.req_in = 4'b0000;
    rst_in = 1'b0;
    tests_run++;
    if ({obs(), sched_if.overrun_out} !== 14'h0) begin
      tests_failed++;
      $display("FAIL rstmid_cleared: got %h want 0", {obs(), sched_if.overrun_out});
    end
    activity = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      activity = activity | sched_if.busy_out | sched_if.mac_en_out | sched_if.done_out;
    end
    tests_run++;
    if (activity !== 1'b0) begin
      tests_failed++;
      $display("FAIL rstmid_no_pass: got activity=%b want 0", activity);
    end
  endtask

  task automatic test_random();
    logic [3:0] mp, mo, g, r;
    logic [1:0] mst, pick;
    logic [3:0] mt;
    logic       me, mc, md, mb, c;
    int         ms, en_cnt, done_cnt;
    rst_in = 1'b1;
    step();
    rst_in = 1'b0;
    mp = 0; mo = 0; mst = 0; mt = 0; ms = 0;
    en_cnt = 0; done_cnt = 0;
    for (int i = 0; i < 900; i++) begin
      r = (i < 800) ? 4'($urandom & $urandom & $urandom & $urandom) : 4'b0000;
      c = (i < 800) && ($urandom_range(0, 15) == 0);
      sched_if.req_in = r;
      sched_if.ovr_clr_in = c;
      g = 0; me = 0; mc = 0; md = 0;
      if (ms == 0) begin
        if (mp != 0) begin
          pick = 0;
          for (int k = 3; k >= 0; k--) if (mp[k]) pick = 2'(k);
          mst = pick;
          g = 4'b0001 << pick;
          ms = 1; mt = 0; me = 1; mc = 1;
        end
      end else if (ms == 1) begin
        if (mt == 4'(N - 1)) begin
          ms = 2; md = 1;
        end else begin
          mt = mt + 1; me = 1;
        end
      end else begin
        ms = 0;
      end
      mb = (ms != 0);
      mo = (c ? 4'b0000 : mo) | (r & mp & ~g);
      mp = (mp & ~g) | r;
      step();
      if (sched_if.mac_en_out) en_cnt++;
      if (sched_if.done_out) done_cnt++;
      tests_run++;
      if ({obs(), sched_if.overrun_out} !== {pack(mb, mst, mt, me, mc, md), mo}) begin
        tests_failed++;
        $display("FAIL random cyc%0d: got %h want %h", i, {obs(), sched_if.overrun_out}, {pack(mb, mst, mt, me, mc, md), mo});
      end
    end
    sched_if.ovr_clr_in = 1'b0;
    tests_run++;
    if (done_cnt == 0 || en_cnt != N * done_cnt) begin
      tests_failed++;
      $display("FAIL random_tap_count: got en=%0d done=%0d want en=%0d*done, done>0", en_cnt, done_cnt, N);
    end
  endtask

  initial begin
    sched_if.req_in = 4'b0000;
    sched_if.ovr_clr_in = 1'b0;
    test_reset();
    test_single();
    test_multi();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
